prefetch_fetcher: RTL and testbench
===================================

PREFETCH_FETCHER -- requirements
Module: prefetch_fetcher

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8, program memory address width.
REQ-002 Parameter PROGRAM_MEM_DATA_BITS, default 16, instruction width.
REQ-003 Parameter QUEUE_DEPTH, default 4, prefetch queue entries, power of two, >= 2.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 core_state  in  3  core state; FETCH=3'b001, DECODE=3'b010.
REQ-007 current_pc  in  ADDR_BITS  PC of the instruction the core needs.
REQ-008 prefetch_en  in  1  1 = sequential prefetch; 0 = demand-fetch only.
REQ-009 mem_read_valid  out  1  program memory read request.
REQ-010 mem_read_address  out  ADDR_BITS  request address.
REQ-011 mem_read_ready  in  1  response valid; data on mem_read_data.
REQ-012 mem_read_data  in  DATA_BITS  response instruction.
REQ-013 fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010.
REQ-014 instruction  out  DATA_BITS  fetched instruction, stable while FETCHED.
REQ-015 queue_count  out  clog2(QUEUE_DEPTH)+1  valid queue entries.
REQ-016 fetch_hit  out  1  one-cycle pulse when FETCH is served from the queue.

Function
REQ-017 Queue SHALL be a circular FIFO; each entry holds {address, instruction}; head = oldest entry.
REQ-018 At most one memory request SHALL be outstanding; mem_read_valid and mem_read_address SHALL be held until the edge where mem_read_ready=1, and valid SHALL deassert on that edge.
REQ-019 A new request SHALL NOT be raised in the same cycle as the preceding response; at least one cycle with valid=0 SHALL separate requests.
REQ-020 Issue rule, prefetch_en=1: issue at next_addr when no request is outstanding and queue_count < QUEUE_DEPTH; then next_addr increments.
REQ-021 Issue rule, prefetch_en=0: issue only while FETCHING with the queue empty.
REQ-022 next_addr SHALL wrap modulo 2^ADDR_BITS, e.g. 8'hFF -> 8'h00.
REQ-023 A non-discarded response SHALL be pushed at the tail; a discarded response SHALL be dropped without any state change.
REQ-024 IDLE: when core_state=FETCH and head is valid with address == current_pc, the next state SHALL be FETCHED, with instruction <= head data and fetch_hit=1 for one cycle.
REQ-025 IDLE miss: when core_state=FETCH and the head is empty or mismatched, the block SHALL move to FETCHING, flush the queue (count=0), and set next_addr <= current_pc.
REQ-026 On a miss, an outstanding request SHALL be kept only if the queue was empty and its address == current_pc (next_addr <= current_pc+1); otherwise it SHALL be marked discard.
REQ-027 FETCHING: on the accepted non-discarded response, the block SHALL move to FETCHED with instruction <= mem_read_data (bypass) and SHALL push that entry too.
REQ-028 FETCHED: when core_state=DECODE, the block SHALL pop the head and move to IDLE; otherwise it SHALL hold.
REQ-029 A push and pop in the same cycle SHALL leave queue_count unchanged; the issue rule SHALL make a push to a full queue impossible.

Reset
REQ-030 When reset=1 the block SHALL set fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, queue_count=0, fetch_hit=0, next_addr=0, and clear the outstanding and discard flags.
REQ-031 Reset mid-request SHALL abandon the request; any mem_read_ready after reset SHALL be ignored while no request is outstanding.

Verification
REQ-032 Cold miss, prefetch_en=0, pc=8'h10, ready 2 cycles after valid: address 8'h10 requested, FETCHED with the returned data, queue_count=1, then 0 after DECODE.
REQ-033 Sequential hit, prefetch_en=1, DEPTH=4, zero-latency memory: after pc=8'h10 misses, requests 8'h11..8'h14 fill the queue (count=4); FETCH at 8'h11 gives fetch_hit=1 and FETCHED the next cycle with no request.
REQ-034 Branch: queue holds 8'h21..8'h23 with 8'h24 outstanding; FETCH pc=8'h40 flushes the queue, drops the 8'h24 response, and the next request is 8'h40.
REQ-035 Wrap: pc=8'hFE, prefetch_en=1: request addresses are 8'hFE, 8'hFF, 8'h00, 8'h01.
REQ-036 Reset asserted while valid=1 at 8'h30, then ready pulsed: valid=0, state IDLE, queue_count=0, instruction=0, and no entry pushed.
REQ-037 Simultaneous push and pop, count=2, prefetch_en=1: DECODE pop on the same edge as a response leaves count=2.

Source files
------------

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher with a sequential prefetch queue. A hit on the queue head takes one cycle; a miss flushes the queue and waits on memory.
// The single outstanding memory request is held until mem_read_ready; stale responses after a redirect are dropped.
module prefetch_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int QUEUE_DEPTH           = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0]   current_pc,
  input  logic                               prefetch_en,
  output logic                               mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0]   mem_read_data,
  output logic [2:0]                         fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction,
  output logic [$clog2(QUEUE_DEPTH):0]       queue_count,
  output logic                               fetch_hit
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(QUEUE_DEPTH);
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  state_t                             state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   q_addr [QUEUE_DEPTH];
  logic [PROGRAM_MEM_DATA_BITS-1:0]   q_data [QUEUE_DEPTH];
  logic [PW-1:0]                      head, tail;
  logic [PW:0]                        count;
  logic                               discard;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   next_addr;

  logic accept, keep_resp, head_match, fetch_req, hit, miss, pop, push, issue, keep_out;

  always_comb begin
    accept     = mem_read_valid && mem_read_ready;
    keep_resp  = accept && !discard;
    head_match = (count != '0) && (q_addr[head] == current_pc);
    fetch_req  = (state == IDLE) && (core_state == CORE_FETCH);
    hit        = fetch_req && head_match;
    miss       = fetch_req && !head_match;
    pop        = (state == FETCHED) && (core_state == CORE_DECODE) && (count != '0);
    push       = keep_resp && !miss;
    // The issue decision never overlaps a response: valid must already be low.
    issue      = !mem_read_valid && !miss &&
                 (prefetch_en ? (count < DEPTH_C) : ((state == FETCHING) && (count == '0)));
    // An in-flight request already targeting the missed PC can serve the miss.
    keep_out   = mem_read_valid && !mem_read_ready && (count == '0) &&
                 (mem_read_address == current_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      fetch_hit        <= 1'b0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      discard          <= 1'b0;
      next_addr        <= '0;
    end else begin
      fetch_hit <= hit;

      if (miss) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_addr[tail] <= mem_read_address;
          q_data[tail] <= mem_read_data;
          tail         <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      if (accept) begin
        mem_read_valid <= 1'b0;
        discard        <= 1'b0;
      end else if (issue) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= next_addr;
        next_addr        <= next_addr + 1'b1;
      end

      if (miss) begin
        if (keep_out) begin
          next_addr <= current_pc + 1'b1;
        end else begin
          next_addr <= current_pc;
          discard   <= mem_read_valid && !mem_read_ready;
        end
      end

      case (state)
        IDLE: begin
          if (hit) begin
            state       <= FETCHED;
            instruction <= q_data[head];
          end else if (miss) begin
            state <= FETCHING;
          end
        end
        FETCHING: begin
          if (keep_resp) begin
            state       <= FETCHED;
            instruction <= mem_read_data;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fetcher_state = state;
  assign queue_count   = count;
endmodule

// File: tb/tb_prefetch_fetcher.sv
// Bench for prefetch_fetcher: directed vector table, directed corner sequences and a
// randomized run, all checked every cycle against a queue-based behavioural model.
module tb_prefetch_fetcher;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        prefetch_en;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [2:0]  queue_count;
  logic        fetch_hit;

  logic zl, rdy_man;

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [7:0] a);
    return {a ^ 8'hC3, ~a};
  endfunction

  assign mem_read_ready = zl ? mem_read_valid : rdy_man;
  assign mem_read_data  = memf(mem_read_address);

  prefetch_fetcher #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .prefetch_en(prefetch_en), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction), .queue_count(queue_count), .fetch_hit(fetch_hit));

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of {addr,data}, one request slot, state as an int.
  typedef struct { logic [7:0] a; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  int          m_state;
  bit          m_valid, m_disc, m_hit;
  logic [7:0]  m_addr, m_next;
  logic [15:0] m_instr;
  logic [7:0]  req_log[$];

  task automatic model_step(input bit rst, input logic [2:0] cs, input logic [7:0] pc,
                            input bit pen, input bit rdy, input logic [15:0] rd);
    bit acc, take, was_valid, was_empty, can_issue;
    ent_t e;
    if (rst) begin
      mq.delete(); m_state = 0; m_valid = 0; m_addr = 0; m_disc = 0;
      m_next = 0; m_instr = 0; m_hit = 0;
      return;
    end
    acc       = m_valid && rdy;
    take      = acc && !m_disc;
    was_valid = m_valid;
    was_empty = (mq.size() == 0);
    can_issue = !m_valid && (pen ? (mq.size() < 4) : (m_state == 1 && was_empty));
    m_hit     = 0;
    e.a = m_addr;
    e.d = rd;
    if (acc) begin m_valid = 0; m_disc = 0; end
    case (m_state)
      0: if (cs == 3'b001) begin
        if (!was_empty && mq[0].a == pc) begin
          m_state = 2; m_instr = mq[0].d; m_hit = 1;
        end else begin
          m_state = 1; mq.delete(); take = 0; can_issue = 0;
          if (was_valid && !acc && was_empty && m_addr == pc) m_next = pc + 8'd1;
          else begin m_next = pc; m_disc = was_valid && !acc; end
        end
      end
      1: if (take) begin m_state = 2; m_instr = rd; end
      2: if (cs == 3'b010) begin
        if (mq.size() > 0) void'(mq.pop_front());
        m_state = 0;
      end
      default: m_state = 0;
    endcase
    if (take) mq.push_back(e);
    if (can_issue) begin m_valid = 1; m_addr = m_next; m_next = m_next + 8'd1; end
  endtask

  task automatic tick();
    bit s_rst, s_pen, s_rdy;
    logic [2:0] s_cs;
    logic [7:0] s_pc;
    logic [15:0] s_rd;
    #1;
    s_rst = reset; s_cs = core_state; s_pc = current_pc; s_pen = prefetch_en;
    s_rdy = mem_read_ready; s_rd = mem_read_data;
    if (mem_read_valid && mem_read_ready && !reset) req_log.push_back(mem_read_address);
    @(posedge clk);
    model_step(s_rst, s_cs, s_pc, s_pen, s_rdy, s_rd);
    #1;
    check("m_state", fetcher_state, m_state);
    check("m_valid", mem_read_valid, m_valid);
    check("m_addr",  mem_read_address, m_addr);
    check("m_instr", instruction, m_instr);
    check("m_count", queue_count, mq.size());
    check("m_hit",   fetch_hit, m_hit);
  endtask

  task automatic do_reset();
    reset = 1; core_state = 0; zl = 0; rdy_man = 0; prefetch_en = 0; current_pc = 0;
    tick();
    reset = 0;
  endtask

  typedef struct {
    bit rst; logic [2:0] cs; logic [7:0] pc; bit pen; bit rdy;
    bit e_vld; logic [7:0] e_addr; logic [2:0] e_st; logic [15:0] e_ins; int e_cnt; bit e_hit;
  } vec_t;
  vec_t tbl[9];

  initial begin
    reset = 1; core_state = 0; current_pc = 0; prefetch_en = 0; zl = 0; rdy_man = 0;

    // Cold miss, demand-only, ready two cycles after valid.
    tbl[0] = '{1, 3'd0, 8'h10, 0, 0,  0, 8'h00, 3'd0, 16'h0000, 0, 0};
    tbl[1] = '{0, 3'd0, 8'h10, 0, 0,  0, 8'h00, 3'd0, 16'h0000, 0, 0};
    tbl[2] = '{0, 3'd1, 8'h10, 0, 0,  0, 8'h00, 3'd1, 16'h0000, 0, 0};
    tbl[3] = '{0, 3'd1, 8'h10, 0, 0,  1, 8'h10, 3'd1, 16'h0000, 0, 0};
    tbl[4] = '{0, 3'd0, 8'h10, 0, 0,  1, 8'h10, 3'd1, 16'h0000, 0, 0};
    tbl[5] = '{0, 3'd0, 8'h10, 0, 0,  1, 8'h10, 3'd1, 16'h0000, 0, 0};
    tbl[6] = '{0, 3'd0, 8'h10, 0, 1,  0, 8'h10, 3'd2, 16'hD3EF, 1, 0};
    tbl[7] = '{0, 3'd2, 8'h10, 0, 0,  0, 8'h10, 3'd0, 16'hD3EF, 0, 0};
    tbl[8] = '{0, 3'd0, 8'h10, 0, 0,  0, 8'h10, 3'd0, 16'hD3EF, 0, 0};
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst; core_state = tbl[i].cs; current_pc = tbl[i].pc;
      prefetch_en = tbl[i].pen; rdy_man = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_vld", i),   mem_read_valid, tbl[i].e_vld);
      check($sformatf("tbl%0d_addr", i),  mem_read_address, tbl[i].e_addr);
      check($sformatf("tbl%0d_state", i), fetcher_state, tbl[i].e_st);
      check($sformatf("tbl%0d_ins", i),   instruction, tbl[i].e_ins);
      check($sformatf("tbl%0d_cnt", i),   queue_count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_hit", i),   fetch_hit, tbl[i].e_hit);
    end

    // Sequential hit with zero-latency memory.
    do_reset();
    prefetch_en = 1; zl = 1;
    repeat (12) tick();
    current_pc = 8'h10; core_state = 3'd1; tick();
    core_state = 3'd0; req_log.delete();
    for (int i = 0; i < 40 && fetcher_state != 3'd2; i++) tick();
    check("seq_fetched", fetcher_state, 3'd2);
    core_state = 3'd2; tick();
    core_state = 3'd0;
    for (int i = 0; i < 40 && queue_count != 3'd4; i++) tick();
    check("seq_full", queue_count, 3'd4);
    check("seq_nreq", req_log.size(), 5);
    for (int i = 0; i < 5 && i < req_log.size(); i++)
      check($sformatf("seq_req%0d", i), req_log[i], 8'h10 + i);
    current_pc = 8'h11; core_state = 3'd1; tick();
    check("seq_hit", fetch_hit, 1'b1);
    check("seq_hit_state", fetcher_state, 3'd2);
    check("seq_hit_noreq", mem_read_valid, 1'b0);
    core_state = 3'd0; tick();
    check("seq_hit_pulse", fetch_hit, 1'b0);
    check("seq_hit_noreq2", mem_read_valid, 1'b0);

    // Branch redirect with an outstanding prefetch.
    do_reset();
    current_pc = 8'h20; core_state = 3'd1; tick();
    core_state = 3'd0; zl = 1;
    for (int i = 0; i < 20 && fetcher_state != 3'd2; i++) tick();
    core_state = 3'd2; tick();
    core_state = 3'd0; prefetch_en = 1;
    for (int i = 0; i < 40 && queue_count != 3'd3; i++) tick();
    zl = 0; rdy_man = 0;
    for (int i = 0; i < 10 && !mem_read_valid; i++) tick();
    check("br_out_addr", mem_read_address, 8'h24);
    check("br_out_cnt", queue_count, 3'd3);
    current_pc = 8'h40; core_state = 3'd1; tick();
    check("br_flush_cnt", queue_count, 3'd0);
    check("br_flush_state", fetcher_state, 3'd1);
    check("br_held_vld", mem_read_valid, 1'b1);
    core_state = 3'd0; rdy_man = 1; tick();
    check("br_drop_vld", mem_read_valid, 1'b0);
    check("br_drop_cnt", queue_count, 3'd0);
    check("br_drop_state", fetcher_state, 3'd1);
    rdy_man = 0; tick();
    check("br_new_vld", mem_read_valid, 1'b1);
    check("br_new_addr", mem_read_address, 8'h40);
    rdy_man = 1; tick();
    check("br_new_ins", instruction, memf(8'h40));
    check("br_new_state", fetcher_state, 3'd2);

    // Address wrap.
    do_reset();
    current_pc = 8'hFE; core_state = 3'd1; tick();
    core_state = 3'd0; req_log.delete(); prefetch_en = 1; zl = 1;
    for (int i = 0; i < 40 && req_log.size() < 4; i++) tick();
    check("wrap_n", req_log.size() >= 4, 1'b1);
    if (req_log.size() >= 4) begin
      check("wrap0", req_log[0], 8'hFE);
      check("wrap1", req_log[1], 8'hFF);
      check("wrap2", req_log[2], 8'h00);
      check("wrap3", req_log[3], 8'h01);
    end

    // Reset in the middle of a request.
    do_reset();
    current_pc = 8'h30; core_state = 3'd1; tick();
    core_state = 3'd0;
    for (int i = 0; i < 10 && !mem_read_valid; i++) tick();
    check("rst_req_addr", mem_read_address, 8'h30);
    reset = 1; tick();
    reset = 0; rdy_man = 1; tick();
    check("rst_vld", mem_read_valid, 1'b0);
    check("rst_state", fetcher_state, 3'd0);
    check("rst_cnt", queue_count, 3'd0);
    check("rst_ins", instruction, 16'h0);
    rdy_man = 0; tick();
    check("rst_cnt2", queue_count, 3'd0);

    // Push and pop on the same edge.
    do_reset();
    current_pc = 8'h50; core_state = 3'd1; tick();
    core_state = 3'd0; zl = 1;
    for (int i = 0; i < 20 && fetcher_state != 3'd2; i++) tick();
    prefetch_en = 1;
    for (int i = 0; i < 20 && queue_count != 3'd2; i++) tick();
    zl = 0; rdy_man = 0;
    for (int i = 0; i < 10 && !mem_read_valid; i++) tick();
    check("pp_out_addr", mem_read_address, 8'h52);
    core_state = 3'd2; rdy_man = 1; tick();
    check("pp_cnt", queue_count, 3'd2);
    check("pp_state", fetcher_state, 3'd0);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom % 256) == 0;
      if (($urandom % 32) == 0) prefetch_en = ~prefetch_en;
      if ((c % 64) == 0) zl = $urandom % 2;
      rdy_man = ($urandom % 3) == 0;
      r = $urandom % 4;
      core_state = (r < 2) ? 3'd1 : (r == 2) ? 3'd2 : 3'($urandom % 8);
      r = $urandom % 4;
      if (r < 2 && mq.size() > 0) current_pc = mq[0].a;
      else if (r == 2)            current_pc = m_addr;
      else                        current_pc = 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
